// File: rtl/polar_pkg.sv
// -----------------------------------------------------------------------------
// polar_pkg
// Shared constants and types for the polar block-averaging stage.
//   PH_180 / PH_360 : phase constants in Q1.9.22 signed degrees
//   GAIN_INV        : 1/1.6468 CORDIC gain compensation in Q0.17
//   GAIN_FRAC       : fraction bits of GAIN_INV
//   blk_state_t     : block accumulation FSM states
// -----------------------------------------------------------------------------
package polar_pkg;

    localparam logic signed [31:0] PH_180 = 32'sh2D00_0000;
    localparam logic signed [31:0] PH_360 = 32'sh5A00_0000;

    localparam int                   GAIN_FRAC = 17;
    localparam logic [GAIN_FRAC-1:0] GAIN_INV  = 17'd79594;

    typedef enum logic {
        EMPTY = 1'b0,
        FILL  = 1'b1
    } blk_state_t;

endpackage

// File: rtl/polar_phase_wrap.sv
// -----------------------------------------------------------------------------
// polar_phase_wrap
// Combinational phase wrap into (-180, 180] degrees.
//   W : working width; must be wider than the 32-bit phase so that values in
//       (-360, 360) are representable.
// Ports:
//   d : signed input phase/difference
//   q : wrapped result, same width
// -----------------------------------------------------------------------------
module polar_phase_wrap
    import polar_pkg::*;
#(
    parameter int W = 33
) (
    input  logic signed [W-1:0] d,
    output logic signed [W-1:0] q
);

    localparam logic signed [W-1:0] P180 = W'(PH_180);
    localparam logic signed [W-1:0] P360 = W'(PH_360);

    always_comb begin
        // NOTE: default assignment first so every path drives q and no latch is inferred.
        q = d;
        if (d > P180) begin
            q = d - P360;
        end else if (d <= -P180) begin
            q = d + P360;
        end
    end

endmodule

// File: rtl/polar_avg_accum.sv
// -----------------------------------------------------------------------------
// polar_avg_accum
// Averages 2^LOG2_NAVG consecutive (magnitude, phase) results from the CORDIC
// rectangular-to-polar converter and emits one averaged pair per block. Phases
// are accumulated as wrapped differences against the first sample of the block,
// so blocks straddling +/-180 degrees average correctly.
//
// Optional feature macro: POLAR_AVG_GAIN_COMP_EN
//   defined   : averaged magnitude is multiplied by GAIN_INV (Q0.17) and
//               truncated; adds one pipeline stage (latency 3)
//   undefined : averaged magnitude passes straight through (latency 2)
//
// Ports:
//   clk     : clock
//   rst     : synchronous active-high reset
//   i_vld   : input sample strobe
//   i_mag   : signed magnitude, negatives clamped to 0
//   i_phase : phase, Q1.9.22 degrees in (-180, 180]
//   i_clr   : abort current block and cancel in-flight result (wins over i_vld)
//   o_vld   : one-cycle pulse per averaged result
//   o_mag   : averaged magnitude, held between pulses
//   o_phase : averaged phase, held between pulses
//   o_cnt   : samples in the current block (0..N-1)
// -----------------------------------------------------------------------------
module polar_avg_accum
    import polar_pkg::*;
#(
    parameter int WIDTH_XY  = 32,
    parameter int WIDTH_PH  = 32,
    parameter int LOG2_NAVG = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_vld,
    input  logic [WIDTH_XY-1:0] i_mag,
    input  logic [WIDTH_PH-1:0] i_phase,
    input  logic                i_clr,
    output logic                o_vld,
    output logic [WIDTH_XY-1:0] o_mag,
    output logic [WIDTH_PH-1:0] o_phase,
    output logic [LOG2_NAVG:0]  o_cnt
);

    localparam int ACC_MAG_W = WIDTH_XY + LOG2_NAVG;
    localparam int ACC_PH_W  = WIDTH_PH + LOG2_NAVG;
    localparam int DIFF_W    = WIDTH_PH + 1;
    localparam logic [LOG2_NAVG:0] LAST_CNT = (LOG2_NAVG + 1)'((1 << LOG2_NAVG) - 1);
    localparam logic [LOG2_NAVG:0] CNT_ONE  = (LOG2_NAVG + 1)'(1);

    // ---------------------------------------------------------------- accumulate
    blk_state_t                  state;
    logic [WIDTH_PH-1:0]         ref_ph;
    logic [ACC_MAG_W-1:0]        mag_acc;
    logic signed [ACC_PH_W-1:0]  ph_acc;

    logic [WIDTH_XY-1:0]         mag_clamp;
    logic [ACC_MAG_W-1:0]        mag_sum;
    logic signed [DIFF_W-1:0]    diff_raw;
    logic signed [DIFF_W-1:0]    diff_wr;
    logic signed [ACC_PH_W-1:0]  ph_sum;
    logic                        take_snap;

    assign mag_clamp = i_mag[WIDTH_XY-1] ? '0 : i_mag;
    assign mag_sum   = mag_acc + ACC_MAG_W'(mag_clamp);
    assign diff_raw  = {i_phase[WIDTH_PH-1], i_phase} - {ref_ph[WIDTH_PH-1], ref_ph};

    polar_phase_wrap #(.W(DIFF_W)) u_wrap_diff (
        .d (diff_raw),
        .q (diff_wr)
    );

    // diff_wr is signed, so the size cast sign-extends into the accumulator width.
    assign ph_sum    = ph_acc + ACC_PH_W'(diff_wr);
    assign take_snap = i_vld && !i_clr && (state == FILL) && (o_cnt == LAST_CNT);

    // ---------------------------------------------------------------- snapshot
    logic                        snap_vld;
    logic [ACC_MAG_W-1:0]        snap_mag;
    logic signed [ACC_PH_W-1:0]  snap_ph;
    logic [WIDTH_PH-1:0]         snap_ref;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst || i_clr) begin
            state    <= EMPTY;
            o_cnt    <= '0;
            mag_acc  <= '0;
            ph_acc   <= '0;
            snap_vld <= 1'b0;
        end else begin
            snap_vld <= take_snap;
            if (i_vld) begin
                unique case (state)
                    EMPTY: begin
                        state   <= FILL;
                        o_cnt   <= CNT_ONE;
                        mag_acc <= ACC_MAG_W'(mag_clamp);
                        ph_acc  <= '0;
                    end
                    FILL: begin
                        if (o_cnt == LAST_CNT) begin
                            state   <= EMPTY;
                            o_cnt   <= '0;
                            mag_acc <= '0;
                            ph_acc  <= '0;
                        end else begin
                            o_cnt   <= o_cnt + CNT_ONE;
                            mag_acc <= mag_sum;
                            ph_acc  <= ph_sum;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

    // NOTE: datapath registers carry no reset; their valid bits gate every use.
    always_ff @(posedge clk) begin
        if (i_vld && (state == EMPTY)) begin
            ref_ph <= i_phase;
        end
        if (take_snap) begin
            snap_mag <= mag_sum;
            snap_ph  <= ph_sum;
            snap_ref <= ref_ph;
        end
    end

    // ---------------------------------------------------------------- mean
    logic [ACC_MAG_W-1:0]        mag_shift;
    logic [WIDTH_XY-1:0]         mean_mag;
    logic signed [ACC_PH_W-1:0]  ph_shift;
    logic signed [DIFF_W-1:0]    mean_sum;
    logic signed [DIFF_W-1:0]    mean_wr;
    logic [WIDTH_PH-1:0]         mean_ph;

    assign mag_shift = snap_mag >> LOG2_NAVG;
    assign mean_mag  = mag_shift[WIDTH_XY-1:0];
    // Arithmetic shift floors the mean difference toward -inf.
    assign ph_shift  = snap_ph >>> LOG2_NAVG;
    assign mean_sum  = ph_shift[DIFF_W-1:0] + {snap_ref[WIDTH_PH-1], snap_ref};

    polar_phase_wrap #(.W(DIFF_W)) u_wrap_mean (
        .d (mean_sum),
        .q (mean_wr)
    );

    assign mean_ph = mean_wr[WIDTH_PH-1:0];

    // Upper bits are zero / pure sign extension after shift and wrap.
    logic unused_bits;
    assign unused_bits = ^{mag_shift[ACC_MAG_W-1:WIDTH_XY], ph_shift[ACC_PH_W-1:WIDTH_PH],
                           mean_wr[DIFF_W-1]};

    // ---------------------------------------------------------------- gain / result
    logic                res_vld;
    logic [WIDTH_XY-1:0] res_mag;
    logic [WIDTH_PH-1:0] res_ph;

`ifdef POLAR_AVG_GAIN_COMP_EN
    logic [WIDTH_XY+GAIN_FRAC-1:0] gain_prod;
    logic                          mid_vld;
    logic [WIDTH_XY-1:0]           mid_mag;
    logic [WIDTH_PH-1:0]           mid_ph;

    assign gain_prod = {{GAIN_FRAC{1'b0}}, mean_mag} * {{WIDTH_XY{1'b0}}, GAIN_INV};

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            mid_vld <= 1'b0;
        end else begin
            mid_vld <= snap_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (snap_vld) begin
            mid_mag <= gain_prod[WIDTH_XY+GAIN_FRAC-1:GAIN_FRAC];
            mid_ph  <= mean_ph;
        end
    end

    logic unused_gain;
    assign unused_gain = ^gain_prod[GAIN_FRAC-1:0];

    assign res_vld = mid_vld;
    assign res_mag = mid_mag;
    assign res_ph  = mid_ph;
`else
    assign res_vld = snap_vld;
    assign res_mag = mean_mag;
    assign res_ph  = mean_ph;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            o_vld   <= 1'b0;
            o_mag   <= '0;
            o_phase <= '0;
        end else begin
            o_vld <= res_vld && !i_clr;
            if (res_vld && !i_clr) begin
                o_mag   <= res_mag;
                o_phase <= res_ph;
            end
        end
    end

endmodule

// File: tb/tb_polar_avg_accum.sv
// -----------------------------------------------------------------------------
// tb_polar_avg_accum
// Directed vectors with hand-computed block averages. The stimulus process
// pushes expected (mag, phase, output cycle) into a scoreboard queue; a
// monitor on the falling edge pops and compares on every o_vld pulse.
// -----------------------------------------------------------------------------
module tb_polar_avg_accum;

    localparam int N = 16;
`ifdef POLAR_AVG_GAIN_COMP_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    localparam logic [31:0] PH0   = 32'h0000_0000;
    localparam logic [31:0] DEG10 = 32'h0280_0000;
    localparam logic [31:0] DEG20 = 32'h0500_0000;
    localparam logic [31:0] DEG30 = 32'h0780_0000;
    localparam logic [31:0] DEG45 = 32'h0B40_0000;
    localparam logic [31:0] M10   = 32'hFD80_0000;
    localparam logic [31:0] M90   = 32'hE980_0000;
    localparam logic [31:0] P179  = 32'h2CC0_0000;
    localparam logic [31:0] M179  = 32'hD340_0000;
    localparam logic [31:0] P180  = 32'h2D00_0000;
    localparam logic [31:0] NEG1  = 32'hFFFF_FFFF;
    localparam logic [31:0] MNEG  = 32'hFFFF_EC78;   // -5000

    logic        clk = 1'b0;
    logic        rst;
    logic        i_vld;
    logic        i_clr;
    logic [31:0] i_mag;
    logic [31:0] i_phase;
    logic        o_vld;
    logic [31:0] o_mag;
    logic [31:0] o_phase;
    logic [4:0]  o_cnt;

    polar_avg_accum #(
        .WIDTH_XY  (32),
        .WIDTH_PH  (32),
        .LOG2_NAVG (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_vld   (i_vld),
        .i_mag   (i_mag),
        .i_phase (i_phase),
        .i_clr   (i_clr),
        .o_vld   (o_vld),
        .o_mag   (o_mag),
        .o_phase (o_phase),
        .o_cnt   (o_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] mag;
        logic [31:0] ph;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   last_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] exp_mag(input logic [31:0] mean);
`ifdef POLAR_AVG_GAIN_COMP_EN
        logic [63:0] p;
        p = ({32'd0, mean} * 64'd79594) >> 17;
        return p[31:0];
`else
        return mean;
`endif
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst === 1'b0 && o_vld === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_o_vld: got o_mag %0h o_phase %0h at cycle %0d expected no output",
                         o_mag, o_phase, cyc);
            end else begin
                e = sb.pop_front();
                check("o_mag", 64'(o_mag), 64'(e.mag));
                check("o_phase", 64'(o_phase), 64'(e.ph));
                check("o_vld_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic send(input logic [31:0] m, input logic [31:0] p);
        @(posedge clk);
        #1;
        i_vld   = 1'b1;
        i_clr   = 1'b0;
        i_mag   = m;
        i_phase = p;
        last_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            i_vld = 1'b0;
            i_clr = 1'b0;
        end
    endtask

    task automatic expect_out(input logic [31:0] mean_mag, input logic [31:0] mean_ph);
        exp_t e;
        e.mag = exp_mag(mean_mag);
        e.ph  = mean_ph;
        e.cyc = last_cyc + LAT;
        sb.push_back(e);
    endtask

    task automatic block(input logic [31:0] m, input logic [31:0] p);
        for (int i = 0; i < N; i++) send(m, p);
        expect_out(m, p);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_o_vld"}, 64'(o_vld), 64'd0);
        check({tag, "_o_mag"}, 64'(o_mag), 64'd0);
        check({tag, "_o_phase"}, 64'(o_phase), 64'd0);
        check({tag, "_o_cnt"}, 64'(o_cnt), 64'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected summary");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst     = 1'b1;
        i_vld   = 1'b0;
        i_clr   = 1'b0;
        i_mag   = '0;
        i_phase = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs_zero("reset");

        // Constant block: mean equals the input.
        block(32'd1000, DEG10);
        idle(4);

        // Alternating +179/-179 averages to 180, not 0.
        for (int i = 0; i < N; i++) send(32'd500, (i % 2 == 0) ? P179 : M179);
        expect_out(32'd500, P180);
        idle(4);

        // Same starting at -179: mean lands on -180 and wraps to +180.
        for (int i = 0; i < N; i++) send(32'd500, (i % 2 == 0) ? M179 : P179);
        expect_out(32'd500, P180);
        idle(4);

        // 32 back-to-back samples: two results 16 cycles apart, o_cnt 0..15 twice.
        for (int i = 0; i < 2 * N; i++) begin
            send((i < N) ? 32'd100 : 32'd300, (i < N) ? M90 : DEG45);
            check("o_cnt_seq", 64'(o_cnt), 64'(i % N));
            if (i == N - 1) expect_out(32'd100, M90);
            if (i == 2 * N - 1) expect_out(32'd300, DEG45);
        end
        idle(1);
        check("o_cnt_wrap", 64'(o_cnt), 64'd0);
        idle(4);

        // Magnitude that exercises gain compensation when enabled.
        block(32'd65536, PH0);
        idle(5);

        // Partial block, then clear with a simultaneous sample.
        for (int i = 0; i < 5; i++) send(32'd9999, DEG10);
        @(posedge clk);
        #1;
        i_clr = 1'b1;
        i_vld = 1'b1;
        i_mag = 32'd9999;
        idle(1);
        check("o_cnt_after_clr", 64'(o_cnt), 64'd0);
        block(32'd200, DEG20);
        idle(5);

        // Clear right after the last sample cancels the in-flight result.
        for (int i = 0; i < N; i++) send(32'd300, DEG10);
        @(posedge clk);
        #1;
        i_vld = 1'b0;
        i_clr = 1'b1;
        idle(6);
        check("o_mag_hold_after_cancel", 64'(o_mag), 64'(exp_mag(32'd200)));

        // Reset mid-block discards partial data.
        for (int i = 0; i < 8; i++) send(32'd777, DEG30);
        @(posedge clk);
        #1;
        i_vld = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs_zero("midrst");
        block(32'd50, M10);
        idle(5);

        // Mixed block: one negative magnitude clamped, phases 10/30 alternate.
        for (int i = 0; i < N; i++) send((i == 7) ? MNEG : 32'd160, (i % 2 == 0) ? DEG10 : DEG30);
        expect_out(32'd150, DEG20);
        idle(4);

        // Floor behaviour: sum of -1 LSB shifts to -1; 17/16 truncates to 1.
        for (int i = 0; i < N; i++) send((i == 0) ? 32'd17 : 32'd0, (i == 9) ? NEG1 : PH0);
        expect_out(32'd1, NEG1);

        // Drain with a bounded wait.
        for (int i = 0; i < 50 && sb.size() != 0; i++) idle(1);
        idle(4);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
